lpc_record_writer: RTL and testbench
====================================

Name: lpc_record_writer

Overview:
- Upstream neighbour of the memory-to-serial streamer.
- Takes one decoded LPC cycle per strobe and packs it into a fixed 8-byte record.
- Writes the record into the shared dual-port record memory, which is organised as a ring of 2^(AW-3) records.
- Publishes the oldest unread record index and an empty flag to the streamer, and retires that record when the streamer signals it has finished reading it.

Parameters:
AW, 16, byte address width of the record memory; the ring holds 2^(AW-3) records of 8 bytes.

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset  in  1  asynchronous, active-high reset
lpc_valid  in  1  one-cycle strobe; the lpc_* fields below are valid in this cycle
lpc_cyctype  in  2  cycle type: 00 IO, 01 memory, 10 DMA, 11 firmware
lpc_dir  in  1  0 = read, 1 = write
lpc_addr  in  32  cycle address; IO cycles use only [15:0], with the upper bits supplied as 0
lpc_data  in  8  data byte
write_addr  out  AW  memory write address, {write record index, byte offset}
write_data  out  8  memory write data
write_enable  out  1  memory write strobe
target_addr  out  AW-3  index of the oldest unread record
read_empty  out  1  1 = no committed unread record
read_done  in  1  level from the consumer; each rising edge retires one record
drop_count  out  8  saturating count of records lost since the last successful commit

Behaviour:
- Reset (asynchronous, active-high): all pointers 0, state IDLE, pending slot empty, write_enable 0, write_addr 0, write_data 0, target_addr 0, read_empty 1, drop_count 0, sequence number 0, read_done edge register 0.
- Record layout, byte offset: value
  - 0: {4'h0, lpc_cyctype, lpc_dir, 1'b0}
  - 1 to 4: lpc_addr, MSB first
  - 5: lpc_data
  - 6: drop_count snapshot taken at capture
  - 7: 8-bit sequence number
- Pending slot:
  - A single holding register, loaded on every lpc_valid.
  - If lpc_valid arrives while the pending slot is still full (not yet taken by the FSM), the new cycle is dropped and drop_count increments, saturating at 255.
- FSM states:
  - IDLE:
    - Pending slot full and ring not full: take the slot (pending becomes empty in the same cycle), clear the byte index, go to WRITE.
    - Pending slot full and ring full (wr_ptr+1 == rd_ptr, modulo ring size): discard the slot and increment drop_count (saturating).
  - WRITE:
    - write_enable = 1 for 8 consecutive cycles.
    - write_addr = {wr_ptr, idx}, with idx running 0 to 7; write_data = record byte idx.
    - After idx 7, go to COMMIT.
  - COMMIT:
    - wr_ptr increments, wrapping modulo ring size.
    - Sequence number increments, wrapping 255 to 0.
    - drop_count clears to 0, unless a drop occurs in this same cycle, in which case it becomes 1.
    - Return to IDLE.
- Latency: lpc_valid sampled at edge N while IDLE gives write_enable high for cycles N+1 to N+8, commit at edge N+9, and read_empty falls at edge N+9.
- One ring slot is always kept unused, so usable capacity is 2^(AW-3)-1 records.
- read_empty = (rd_ptr == wr_ptr), registered. target_addr = rd_ptr.
- Partially written records are never visible, because wr_ptr advances only in COMMIT.
- Retire: a rising edge of read_done (read_done & ~read_done_q) with read_empty = 0 increments rd_ptr, wrapping. A rising edge while empty is ignored.
- Commit and retire in the same cycle: both pointers update, and read_empty/full are computed from both new values.
- Reset during WRITE: the in-flight record is abandoned and rd_ptr = wr_ptr = 0; memory contents are don't-care.

Decomposition:
- Shared package lpc_sniffer_pkg holds:
  - cycle-type codes;
  - RECORD_BYTES = 8;
  - record byte offset constants (OFS_TYPE, OFS_ADDR3 to OFS_ADDR0, OFS_DATA, OFS_DROP, OFS_SEQ);
  - a packed record struct.
- Sub-module lpc_rec_ring_ptr holds:
  - wr_ptr and rd_ptr;
  - the full/empty flags;
  - read_done edge detection.
  It has inputs commit and retire_level, and outputs target_addr, read_empty, ring_full, wr_ptr.

Test Plan:
1. Single capture: after reset, one lpc_valid with cyctype 00, dir 1, addr 0x00000080, data 0x5A -> memory addresses 0 to 7 receive 02,00,00,00,80,5A,00,00; read_empty falls at edge N+9; target_addr = 0.
2. Retire: raise read_done and hold it for 5 cycles -> rd_ptr advances exactly once and read_empty returns to 1; a second rising edge while empty causes no change.
3. Ring full with AW=6 (8 slots): inject 9 cycles with no retire -> 7 records are committed, then drops occur and drop_count = 2. After one retire, the next capture writes byte 6 = 2, and drop_count reads 0 after its commit.
4. Back-to-back strobes: lpc_valid on 3 consecutive cycles -> the first record writes, the second is held in the pending slot, the third is dropped; drop_count = 1 and the seq bytes are 0x00 and 0x01.
5. Simultaneous commit and retire_edge in the same cycle -> both pointers advance and read_empty stays consistent (0 if records remain).
6. Reset asserted mid-WRITE at idx 4 -> all outputs go to their reset values immediately (asynchronously), and read_empty = 1 after release.

Source files
------------

// File: rtl/lpc_sniffer_pkg.sv
// Shared types for the LPC sniffer record path.
// Cycle codes, record layout, byte offsets, writer FSM states.
package lpc_sniffer_pkg;

  localparam logic [1:0] CYC_IO  = 2'b00;
  localparam logic [1:0] CYC_MEM = 2'b01;
  localparam logic [1:0] CYC_DMA = 2'b10;
  localparam logic [1:0] CYC_FW  = 2'b11;

  localparam int RECORD_BYTES = 8;

  localparam logic [2:0] OFS_TYPE  = 3'd0;
  localparam logic [2:0] OFS_ADDR3 = 3'd1;
  localparam logic [2:0] OFS_ADDR2 = 3'd2;
  localparam logic [2:0] OFS_ADDR1 = 3'd3;
  localparam logic [2:0] OFS_ADDR0 = 3'd4;
  localparam logic [2:0] OFS_DATA  = 3'd5;
  localparam logic [2:0] OFS_DROP  = 3'd6;
  localparam logic [2:0] OFS_SEQ   = 3'd7;

  typedef struct packed {
    logic [7:0]  typ;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [7:0]  drop;
    logic [7:0]  seq;
  } lpc_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_COMMIT
  } wr_state_t;

  function automatic logic [7:0] rec_byte(
    input lpc_rec_t   r,
    input logic [2:0] i
  );
    logic [7:0] b;
    b = '0;
    unique case (i)
      OFS_TYPE:  b = r.typ;
      OFS_ADDR3: b = r.addr[31:24];
      OFS_ADDR2: b = r.addr[23:16];
      OFS_ADDR1: b = r.addr[15:8];
      OFS_ADDR0: b = r.addr[7:0];
      OFS_DATA:  b = r.data;
      OFS_DROP:  b = r.drop;
      OFS_SEQ:   b = r.seq;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lpc_record_writer_ring_ptr.sv
// Ring pointers for the LPC record writer.
// Holds wr/rd pointers, full/empty flags, read_done edge detect.
import lpc_sniffer_pkg::*;

module lpc_rec_ring_ptr #(
  parameter int AW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          commit,
  input  logic          retire_level,
  output logic [AW-4:0] target_addr,
  output logic          read_empty,
  output logic          ring_full,
  output logic [AW-4:0] wr_ptr
);

  localparam int PW = AW - 3;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_n;
  logic [PW-1:0] rd_n;
  logic          done_q;
  logic          retire;

  // One retire per rising edge of the consumer's level.
  assign retire = retire_level & ~done_q & ~read_empty;
  assign wr_n   = wr_ptr + PW'(commit);
  assign rd_n   = rd_ptr + PW'(retire);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done_q     <= 1'b0;
      read_empty <= 1'b1;
      ring_full  <= 1'b0;
    end else begin
      wr_ptr     <= wr_n;
      rd_ptr     <= rd_n;
      done_q     <= retire_level;
      // Flags follow the post-update pointers so that
      // a commit and a retire in one cycle stay coherent.
      read_empty <= (rd_n == wr_n);
      ring_full  <= ((wr_n + PW'(1)) == rd_n);
    end
  end

  assign target_addr = rd_ptr;

endmodule

// File: rtl/lpc_record_writer.sv
// Packs one LPC cycle per strobe into an 8-byte ring record.
// In: clock, reset, lpc_*, read_done. Out: write_*, target_addr, read_empty, drop_count.
import lpc_sniffer_pkg::*;

module lpc_record_writer #(
  parameter int AW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lpc_valid,
  input  logic [1:0]    lpc_cyctype,
  input  logic          lpc_dir,
  input  logic [31:0]   lpc_addr,
  input  logic [7:0]    lpc_data,
  output logic [AW-1:0] write_addr,
  output logic [7:0]    write_data,
  output logic          write_enable,
  output logic [AW-4:0] target_addr,
  output logic          read_empty,
  input  logic          read_done,
  output logic [7:0]    drop_count
);

  localparam int PW = AW - 3;

  wr_state_t     state, state_n;
  lpc_rec_t      pend, rec, rec_n;
  logic          pend_full;
  logic [2:0]    idx, idx_n;
  logic [7:0]    seq;
  logic [PW-1:0] wr_ptr;
  logic          ring_full;

  logic          we_n;
  logic [AW-1:0] wa_n;
  logic [7:0]    wd_n;
  logic          commit;
  logic          slot_free;
  logic          idle_drop;
  logic          pend_drop;
  logic          drop;
  logic [7:0]    drop_n;

  lpc_rec_ring_ptr #(.AW(AW)) u_ptr (
    .clock        (clock),
    .reset        (reset),
    .commit       (commit),
    .retire_level (read_done),
    .target_addr  (target_addr),
    .read_empty   (read_empty),
    .ring_full    (ring_full),
    .wr_ptr       (wr_ptr)
  );

  // Write port is registered; byte 0 is issued on the
  // take edge so the burst spans edges N+1..N+8.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    rec_n     = rec;
    we_n      = 1'b0;
    wa_n      = write_addr;
    wd_n      = write_data;
    commit    = 1'b0;
    slot_free = 1'b0;
    idle_drop = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pend_full) begin
          slot_free = 1'b1;
          if (!ring_full) begin
            rec_n     = pend;
            rec_n.seq = seq;
            we_n      = 1'b1;
            wa_n      = {wr_ptr, OFS_TYPE};
            wd_n      = pend.typ;
            idx_n     = 3'd1;
            state_n   = ST_WRITE;
          end else begin
            idle_drop = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        we_n  = 1'b1;
        wa_n  = {wr_ptr, idx};
        wd_n  = rec_byte(rec, idx);
        idx_n = idx + 3'd1;
        if (idx == OFS_SEQ) state_n = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A slot being taken or discarded this cycle can
  // accept the new strobe.
  assign pend_drop = lpc_valid & pend_full & ~slot_free;
  assign drop      = pend_drop | idle_drop;

  always_comb begin
    drop_n = drop_count;
    if (commit)
      drop_n = drop ? 8'd1 : 8'd0;
    else if (drop && drop_count != 8'hFF)
      drop_n = drop_count + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      rec          <= '0;
      pend         <= '0;
      pend_full    <= 1'b0;
      seq          <= '0;
      drop_count   <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      rec          <= rec_n;
      write_enable <= we_n;
      write_addr   <= wa_n;
      write_data   <= wd_n;
      seq          <= seq + {7'd0, commit};
      drop_count   <= drop_n;
      if (lpc_valid && !pend_drop) begin
        pend.typ  <= {4'h0, lpc_cyctype, lpc_dir, 1'b0};
        pend.addr <= lpc_addr;
        pend.data <= lpc_data;
        pend.drop <= drop_count;
        pend.seq  <= '0;
        pend_full <= 1'b1;
      end else if (slot_free) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lpc_record_writer.sv
// Scoreboard bench for lpc_record_writer (AW=6, 8-slot ring).
// Reference model tracks ring occupancy, pending slot and drops.
module tb_lpc_record_writer;

  localparam int AW    = 6;
  localparam int PW    = AW - 3;
  localparam int SLOTS = 1 << PW;

  logic          clock;
  logic          reset;
  logic          lpc_valid;
  logic [1:0]    lpc_cyctype;
  logic          lpc_dir;
  logic [31:0]   lpc_addr;
  logic [7:0]    lpc_data;
  logic [AW-1:0] write_addr;
  logic [7:0]    write_data;
  logic          write_enable;
  logic [PW-1:0] target_addr;
  logic          read_empty;
  logic          read_done;
  logic [7:0]    drop_count;

  lpc_record_writer #(.AW(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .lpc_valid    (lpc_valid),
    .lpc_cyctype  (lpc_cyctype),
    .lpc_dir      (lpc_dir),
    .lpc_addr     (lpc_addr),
    .lpc_data     (lpc_data),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .target_addr  (target_addr),
    .read_empty   (read_empty),
    .read_done    (read_done),
    .drop_count   (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;
  wr_t exp_q[$];

  bit            mp_full;
  logic [7:0]    mp_typ;
  logic [31:0]   mp_addr;
  logic [7:0]    mp_data;
  logic [7:0]    mp_snap;
  int            m_busy;
  int            m_count;
  logic [PW-1:0] m_wr;
  logic [PW-1:0] m_rd;
  logic [7:0]    m_seq;
  logic [7:0]    m_drop;
  logic          m_done_q;

  bit m_slot_free, m_idle_drop, m_pend_drop, m_commit, m_retire;
  logic [7:0] m_bytes [8];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mp_full  = 0;
      m_busy   = 0;
      m_count  = 0;
      m_wr     = '0;
      m_rd     = '0;
      m_seq    = '0;
      m_drop   = '0;
      m_done_q = 1'b0;
      exp_q.delete();
    end else begin
      m_slot_free = 0;
      m_idle_drop = 0;
      m_commit    = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_commit = 1;
      end else if (mp_full) begin
        m_slot_free = 1;
        if (m_count < SLOTS - 1) begin
          m_bytes[0] = mp_typ;
          m_bytes[1] = mp_addr[31:24];
          m_bytes[2] = mp_addr[23:16];
          m_bytes[3] = mp_addr[15:8];
          m_bytes[4] = mp_addr[7:0];
          m_bytes[5] = mp_data;
          m_bytes[6] = mp_snap;
          m_bytes[7] = m_seq;
          for (int i = 0; i < 8; i++)
            exp_q.push_back('{a: AW'(m_wr * 8 + i), d: m_bytes[i]});
          m_busy = 8;
        end else begin
          m_idle_drop = 1;
        end
      end
      m_retire    = read_done && !m_done_q && (m_count > 0);
      m_pend_drop = lpc_valid && mp_full && !m_slot_free;
      if (lpc_valid && !m_pend_drop) begin
        mp_typ  = {4'h0, lpc_cyctype, lpc_dir, 1'b0};
        mp_addr = lpc_addr;
        mp_data = lpc_data;
        mp_snap = m_drop;
        mp_full = 1;
      end else if (m_slot_free) begin
        mp_full = 0;
      end
      if (m_commit)
        m_drop = (m_pend_drop || m_idle_drop) ? 8'd1 : 8'd0;
      else if ((m_pend_drop || m_idle_drop) && m_drop != 8'hFF)
        m_drop = m_drop + 8'd1;
      if (m_commit) begin
        m_seq = m_seq + 8'd1;
        m_wr  = m_wr + 1'b1;
        m_count++;
      end
      if (m_retire) begin
        m_rd = m_rd + 1'b1;
        m_count--;
      end
      m_done_q = read_done;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {26'd0, write_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", {26'd0, write_addr}, {26'd0, e.a});
          chk("write_data", {24'd0, write_data}, {24'd0, e.d});
        end
      end
      chk("read_empty", {31'd0, read_empty}, {31'd0, m_count == 0});
      chk("target_addr", {29'd0, target_addr}, {29'd0, m_rd});
      chk("drop_count", {24'd0, drop_count}, {24'd0, m_drop});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic put(input logic [1:0] ct, input logic dir,
                     input logic [31:0] a, input logic [7:0] d);
    lpc_valid   = 1'b1;
    lpc_cyctype = ct;
    lpc_dir     = dir;
    lpc_addr    = a;
    lpc_data    = d;
    @(negedge clock);
    lpc_valid = 1'b0;
  endtask

  task automatic put_rand();
    logic [1:0]  ct;
    logic [31:0] a;
    ct = 2'($urandom);
    a  = $urandom;
    if (ct == 2'b00) a[31:16] = 16'h0;
    put(ct, 1'($urandom), a, 8'($urandom));
  endtask

  task automatic retire_once();
    read_done = 1'b1;
    idle(2);
    read_done = 1'b0;
    idle(2);
  endtask

  logic [PW-1:0] t0, t1;
  bit            found;

  initial begin
    reset       = 1'b1;
    lpc_valid   = 1'b0;
    lpc_cyctype = '0;
    lpc_dir     = 1'b0;
    lpc_addr    = '0;
    lpc_data    = '0;
    read_done   = 1'b0;
    #12;
    chk("rst_we", {31'd0, write_enable}, 32'd0);
    chk("rst_waddr", {26'd0, write_addr}, 32'd0);
    chk("rst_wdata", {24'd0, write_data}, 32'd0);
    chk("rst_target", {29'd0, target_addr}, 32'd0);
    chk("rst_empty", {31'd0, read_empty}, 32'd1);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);

    // single capture with latency checks
    put(2'b00, 1'b1, 32'h0000_0080, 8'h5A);
    @(negedge clock);
    chk("t1_first_we", {31'd0, write_enable}, 32'd1);
    chk("t1_first_addr", {26'd0, write_addr}, 32'd0);
    chk("t1_first_data", {24'd0, write_data}, 32'h02);
    idle(7);
    chk("t1_last_addr", {26'd0, write_addr}, 32'd7);
    chk("t1_empty_n8", {31'd0, read_empty}, 32'd1);
    @(negedge clock);
    chk("t1_empty_n9", {31'd0, read_empty}, 32'd0);
    chk("t1_we_off", {31'd0, write_enable}, 32'd0);
    chk("t1_target", {29'd0, target_addr}, 32'd0);
    idle(2);

    // retire: hold level, then edge while empty
    read_done = 1'b1;
    idle(5);
    read_done = 1'b0;
    idle(1);
    chk("t2_target", {29'd0, target_addr}, 32'd1);
    chk("t2_empty", {31'd0, read_empty}, 32'd1);
    retire_once();
    chk("t2_target_empty_edge", {29'd0, target_addr}, 32'd1);

    // ring full: 7 commits then 2 drops
    for (int i = 0; i < 9; i++) begin
      put_rand();
      idle(11);
    end
    chk("t3_drop2", {24'd0, drop_count}, 32'd2);
    chk("t3_not_empty", {31'd0, read_empty}, 32'd0);
    retire_once();
    put_rand();
    idle(7);
    chk("t3_ofs6_addr", {29'd0, write_addr[2:0]}, 32'd6);
    chk("t3_ofs6_snap", {24'd0, write_data}, 32'd2);
    idle(2);
    chk("t3_drop_clr", {24'd0, drop_count}, 32'd0);
    idle(2);
    // saturation with the ring full
    lpc_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      lpc_addr = $urandom;
      @(negedge clock);
    end
    lpc_valid = 1'b0;
    idle(3);
    chk("t3_drop_sat", {24'd0, drop_count}, 32'd255);
    for (int i = 0; i < SLOTS - 1; i++) retire_once();
    chk("t3_drained", {31'd0, read_empty}, 32'd1);

    // back-to-back strobes after a fresh reset
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    lpc_valid = 1'b1;
    lpc_cyctype = 2'b01; lpc_dir = 1'b0; lpc_addr = 32'h1111_2222;
    lpc_data = 8'hA1;
    @(negedge clock);
    lpc_cyctype = 2'b10; lpc_addr = 32'h3333_4444; lpc_data = 8'hB2;
    @(negedge clock);
    lpc_cyctype = 2'b11; lpc_addr = 32'h5555_6666; lpc_data = 8'hC3;
    @(negedge clock);
    lpc_valid = 1'b0;
    chk("t4_drop1", {24'd0, drop_count}, 32'd1);
    idle(20);

    // commit and retire on the same edge
    put_rand();
    idle(8);
    t0 = target_addr;
    read_done = 1'b1;
    @(negedge clock);
    t1 = t0 + 1'b1;
    chk("t5_target", {29'd0, target_addr}, {29'd0, t1});
    chk("t5_empty", {31'd0, read_empty}, 32'd0);
    read_done = 1'b0;
    idle(12);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) read_done = ~read_done;
      if ($urandom_range(0, 6) == 0) put_rand();
      else @(negedge clock);
    end
    read_done = 1'b0;
    idle(12);

    // async reset mid-write at offset 4
    put_rand();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (write_enable && write_addr[2:0] == 3'd4) found = 1;
      else @(negedge clock);
    end
    chk("t6_reached_idx4", {31'd0, found}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_we", {31'd0, write_enable}, 32'd0);
    chk("t6_waddr", {26'd0, write_addr}, 32'd0);
    chk("t6_wdata", {24'd0, write_data}, 32'd0);
    chk("t6_target", {29'd0, target_addr}, 32'd0);
    chk("t6_empty", {31'd0, read_empty}, 32'd1);
    chk("t6_drop", {24'd0, drop_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(3);
    chk("t6_empty_after", {31'd0, read_empty}, 32'd1);

    idle(5);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
